patch_emb_collector: RTL

Producer-side front end for the classification head. Accepts a streamed frame of N patch embeddings (E elements each, LANES elements per beat) over a valid/ready handshake and assembles it into a flat N*E buffer. It then pulses start to the head and holds the buffer stable until the head reports out_valid. Only then does it accept the next frame.

---
 rtl/tva_pkg.sv | 15 +
 rtl/patch_emb_collector.sv | 101 ++++++++++
 2 files changed

// File: rtl/tva_pkg.sv
// Shared types for the classification-head front end: element type and
// collector state encoding.
package tva_pkg;

    localparam int ELEM_WIDTH = 16;

    typedef logic signed [ELEM_WIDTH-1:0] data_t;

    typedef enum logic [1:0] {
        FILL   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2
    } state_t;

endpackage

// File: rtl/patch_emb_collector.sv
// Collects a streamed frame of N patch embeddings into a flat buffer, launches
// the head with a one-cycle start pulse and holds the buffer until head_done.
module patch_emb_collector
    import tva_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int E          = 64,
    parameter int N          = 16,
    parameter int LANES      = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [LANES*DATA_WIDTH-1:0]   in_data,
    input  logic                          in_last,
    output logic [N*E*DATA_WIDTH-1:0]     patch_emb_out,
    output logic                          start_out,
    input  logic                          head_done,
    output logic                          busy,
    output logic                          frame_err,
    output logic [15:0]                   frame_cnt
);

    localparam int BEATS = N * E / LANES;
    localparam int CNT_W = $clog2(BEATS) + 1;
    localparam int IDX_W = $clog2(N * E);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    if (E % LANES != 0) begin : g_lanes_check
        $error("patch_emb_collector: E must be a multiple of LANES");
    end

    state_t                         state;
    state_t                         state_next;
    logic [CNT_W-1:0]               beat_cnt;
    logic signed [DATA_WIDTH-1:0]   buffer [N*E];
    logic                           accept;
    logic                           final_beat;

    // Ready depends on state alone, so there is no in_valid -> in_ready path.
    assign in_ready   = (state == FILL);
    assign busy       = (state != FILL);
    assign accept     = in_valid && in_ready;
    assign final_beat = (beat_cnt == LAST_BEAT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= FILL;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            FILL:    if (accept && final_beat) state_next = LAUNCH;
            LAUNCH:  state_next = WAIT;
            WAIT:    if (head_done) state_next = FILL;
            default: state_next = FILL;
        endcase
    end

    // A misplaced in_last aborts a short frame but never a full one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat_cnt  <= '0;
            start_out <= 1'b0;
            frame_err <= 1'b0;
            frame_cnt <= '0;
        end else begin
            start_out <= accept && final_beat;
            frame_err <= accept && (final_beat ? !in_last : in_last);
            if (accept) begin
                beat_cnt <= (final_beat || in_last) ? '0 : beat_cnt + CNT_W'(1);
            end
            if (accept && final_beat) begin
                frame_cnt <= frame_cnt + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N * E; i++) begin
                buffer[i] <= '0;
            end
        end else if (accept) begin
            for (int k = 0; k < LANES; k++) begin
                buffer[IDX_W'(int'(beat_cnt) * LANES + k)] <=
                    $signed(in_data[k*DATA_WIDTH +: DATA_WIDTH]);
            end
        end
    end

    for (genvar i = 0; i < N * E; i++) begin : g_out
        assign patch_emb_out[i*DATA_WIDTH +: DATA_WIDTH] = buffer[i];
    end

endmodule
